// File: rtl/lr3_pkg.sv
// Shared seven-segment constants for the hex sequence display.
package lr3_pkg;

    localparam int unsigned SEG_W = 7;

    typedef logic [3:0]       hex_t;
    typedef logic [SEG_W-1:0] seg_t;

    // Segments {g,f,e,d,c,b,a}, active-low, indexed by hex value.
    localparam seg_t SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex7seg.sv
// Purely combinational hex nibble to active-low seven-segment decode.
module hex7seg
    import lr3_pkg::*;
(
    input  logic [3:0]       hex,
    output logic [SEG_W-1:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/hex_seq_display.sv
// Hex digit shift register with a scanned seven-segment display and a
// sliding-window pattern detector over the most recent digits.
module hex_seq_display
    import lr3_pkg::*;
#(
    parameter int unsigned         N_DIG      = 8,
    parameter int unsigned         PAT_LEN    = 4,
    parameter logic [4*PAT_LEN-1:0] PATTERN   = 16'h220B,
    parameter bit                  BLANK_LEAD = 1'b1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       BTN_CE,
    input  logic [3:0]                 DAT_I,
    input  logic                       DISP_CE,
    output logic [SEG_W-1:0]           CAT,
    output logic [N_DIG-1:0]           AN,
    output logic                       MATCH,
    output logic [$clog2(N_DIG+1)-1:0] FILL,
    output logic [7:0]                 HITS
);

    localparam int unsigned FW = $clog2(N_DIG + 1);
    localparam int unsigned IW = $clog2(N_DIG);

    generate
        if ((N_DIG < 2) || (N_DIG > 16) || (PAT_LEN < 1) || (PAT_LEN > N_DIG)) begin : g_bad_params
            $error("hex_seq_display: illegal N_DIG/PAT_LEN combination");
        end
    endgenerate

    logic [N_DIG-1:0][3:0] digit_q, digit_n;
    logic [FW-1:0]         fill_q, fill_n;
    logic [IW-1:0]         idx_q, idx_n;
    logic                  match_q, match_n;
    logic [7:0]            hits_q;
    logic [3:0]            cur_hex;
    logic [SEG_W-1:0]      cur_seg;
    logic                  blank;

    // Next-state: shift in digits, count fill, advance scan, look for the pattern.
    always_comb begin
        digit_n = digit_q;
        fill_n  = fill_q;
        idx_n   = idx_q;
        match_n = 1'b0;
        if (BTN_CE) begin
            digit_n = {digit_q[N_DIG-2:0], DAT_I};
            if (fill_q != FW'(N_DIG)) begin
                fill_n = fill_q + FW'(1);
            end
        end
        if (DISP_CE) begin
            idx_n = (idx_q == IW'(N_DIG - 1)) ? '0 : idx_q + IW'(1);
        end
        if (BTN_CE && (fill_n >= FW'(PAT_LEN)) && (digit_n[PAT_LEN-1:0] == PATTERN)) begin
            match_n = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            digit_q <= '0;
            fill_q  <= '0;
            idx_q   <= '0;
            match_q <= 1'b0;
            hits_q  <= '0;
        end else begin
            digit_q <= digit_n;
            fill_q  <= fill_n;
            idx_q   <= idx_n;
            match_q <= match_n;
            if (match_n && (hits_q != 8'hFF)) begin
                hits_q <= hits_q + 8'd1;
            end
        end
    end

    // Display path is a pure decode of registered state, so it tracks each edge directly.
    assign cur_hex = digit_q[idx_q];
    assign blank   = BLANK_LEAD && (FW'(idx_q) >= fill_q);

    hex7seg u_hex7seg (
        .hex (cur_hex),
        .seg (cur_seg)
    );

    assign CAT   = blank ? SEG_BLANK : cur_seg;
    assign AN    = blank ? '1 : ~(N_DIG'(1) << idx_q);
    assign MATCH = match_q;
    assign FILL  = fill_q;
    assign HITS  = hits_q;

endmodule
